// File: rtl/regr_queue_pkg.sv
// -----------------------------------------------------------------------------
// regr_queue_pkg
// Shared constants for the ALU result queue: flag bit positions inside the
// {N,O,C,Z} flag vector, the flag-vector width and the "no operation" ALU
// select code that does not request a push.
// -----------------------------------------------------------------------------
package regr_queue_pkg;

  localparam int NFLAGS = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_N = 3;

  localparam logic [1:0] OP_NOP = 2'b00;

endpackage : regr_queue_pkg

// File: rtl/regr_queue_ctrl.sv
// -----------------------------------------------------------------------------
// regr_queue_ctrl
// Pointer / occupancy bookkeeping for the DEPTH-entry circular result queue.
//
// Ports:
//   clk        system clock
//   grst_n     global synchronous reset, active-low
//   lrst       local synchronous clear, active-high
//   push_i     push request this edge
//   pop_i      pop request this edge (ignored when empty)
//   wr_en_o    storage write strobe for the entry at wr_ptr_o
//   wr_ptr_o   write pointer
//   rd_ptr_o   read (head) pointer
//   count_o    current occupancy, 0..DEPTH
//   full_o     count_o == DEPTH
//   empty_o    count_o == 0
//   ovf_err_o  sticky: a push arrived while full without a pop
// -----------------------------------------------------------------------------
module regr_queue_ctrl #(
  parameter  int DEPTH     = 4,
  parameter  bit OVERWRITE = 1'b1,
  localparam int PW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          grst_n,
  input  logic          lrst,
  input  logic          push_i,
  input  logic          pop_i,
  output logic          wr_en_o,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o,
  output logic          ovf_err_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          clear;
  logic          do_pop;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign wr_ptr_o  = wr_ptr_q;
  assign rd_ptr_o  = rd_ptr_q;
  assign count_o   = count_q;
  assign ovf_err_o = ovf_q;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    clear    = !grst_n || lrst;
    do_pop   = pop_i && !empty_o;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    wr_en_o  = 1'b0;

    if (!clear) begin
      if (push_i && full_o && !do_pop) begin
        // Full and nothing leaving: either evict the oldest entry or drop
        // the incoming one; both count as an overflow.
        ovf_d = 1'b1;
        if (OVERWRITE) begin
          wr_en_o  = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
      end else begin
        if (push_i) begin
          wr_en_o  = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        unique case ({push_i, do_pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule : regr_queue_ctrl

// File: rtl/regr_queue.sv
// -----------------------------------------------------------------------------
// regr_queue
// DEPTH-entry circular queue of ALU results with their {N,O,C,Z} flags, plus
// an accumulated (sticky) flag register, read back over a shared tri-state bus.
//
// Ports:
//   clk, grst_n, lrst     clock, global sync reset (low), local sync clear (high)
//   op_sel                ALU op select; any non-NOP value pushes {flags,res}
//   res, Z, C, O, N       ALU result and flags
//   ws1 / ws2 / ws3       bus drive selects: head result / head flags / sticky
//                         (priority ws1 > ws2 > ws3; none -> bus released)
//   pop                   consume head entry
//   clr_sticky            clear sticky flags (a same-edge push still ORs in)
//   bus                   shared data bus, driven only, never sampled
//   count, full, empty    occupancy status
//   ovf_err               sticky overflow error, cleared only by reset
// -----------------------------------------------------------------------------
module regr_queue
  import regr_queue_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b1
) (
  input  logic                       clk,
  input  logic                       grst_n,
  input  logic                       lrst,
  input  logic [1:0]                 op_sel,
  input  logic [WIDTH-1:0]           res,
  input  logic                       Z,
  input  logic                       C,
  input  logic                       O,
  input  logic                       N,
  input  logic                       ws1,
  input  logic                       ws2,
  input  logic                       ws3,
  input  logic                       pop,
  input  logic                       clr_sticky,
  inout  wire  [WIDTH-1:0]           bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_err
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [NFLAGS-1:0] flags;
    logic [WIDTH-1:0]  res;
  } entry_t;

  logic              push;
  logic              wr_en;
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [NFLAGS-1:0] flags_in;
  logic [NFLAGS-1:0] sticky_q, sticky_d;
  entry_t            mem_q [DEPTH];
  entry_t            head;
  logic [WIDTH-1:0]  bus_drv;
  logic              bus_en;

  assign push = (op_sel != OP_NOP);

  always_comb begin
    flags_in         = '0;
    flags_in[FLAG_Z] = Z;
    flags_in[FLAG_C] = C;
    flags_in[FLAG_O] = O;
    flags_in[FLAG_N] = N;
  end

  regr_queue_ctrl #(
    .DEPTH     (DEPTH),
    .OVERWRITE (OVERWRITE)
  ) u_ctrl (
    .clk       (clk),
    .grst_n    (grst_n),
    .lrst      (lrst),
    .push_i    (push),
    .pop_i     (pop),
    .wr_en_o   (wr_en),
    .wr_ptr_o  (wr_ptr),
    .rd_ptr_o  (rd_ptr),
    .count_o   (count),
    .full_o    (full),
    .empty_o   (empty),
    .ovf_err_o (ovf_err)
  );

  // NOTE: storage has no reset; the pointers and count decide what is valid,
  // and empty-queue reads are masked at the bus mux.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr] <= '{flags: flags_in, res: res};
    end
  end

  // Clear happens before the OR, so a push coinciding with clr_sticky leaves
  // exactly its own flags.
  always_comb begin
    sticky_d = clr_sticky ? '0 : sticky_q;
    if (push) begin
      sticky_d = sticky_d | flags_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!grst_n || lrst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    head    = mem_q[rd_ptr];
    bus_en  = 1'b1;
    bus_drv = '0;
    if (ws1) begin
      bus_drv = empty ? '0 : head.res;
    end else if (ws2) begin
      bus_drv = empty ? '0 : WIDTH'(head.flags);
    end else if (ws3) begin
      bus_drv = WIDTH'(sticky_q);
    end else begin
      bus_en  = 1'b0;
    end
  end

  assign bus = bus_en ? bus_drv : {WIDTH{1'bz}};

endmodule : regr_queue

// File: doc/regr_queue.md
Name: regr_queue

Overview:
- Parametrised successor to the single-entry ALU result/flag register.
- Captures each ALU result together with its Z/C/O/N flags into a DEPTH-entry circular queue, so the microcode sequencer can read results back in order over the shared tri-state data bus.
- Adds a sticky (accumulated) flag register and occupancy/overflow status.
- Sits between the ALU outputs and the data bus.

Parameters:
- WIDTH, 4, data/result width in bits; must be >= 4.
- DEPTH, 4, number of queue entries; power of two, >= 2.
- OVERWRITE, 1, full-queue policy: 1 = drop oldest entry and store new one; 0 = drop incoming push.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- grst_n  in  1  global reset, synchronous, active-low.
- lrst  in  1  local clear, synchronous, active-high; same effect as grst_n=0.
- op_sel  in  2  ALU operation select; any value != 2'b00 is a push request.
- res  in  WIDTH  ALU result.
- Z, C, O, N  in  1 each  ALU flags: zero, carry, overflow, negative.
- ws1  in  1  drive head result onto bus.
- ws2  in  1  drive head flags onto bus, as {N,O,C,Z} zero-extended to WIDTH.
- ws3  in  1  drive sticky flags onto bus, as {N,O,C,Z} zero-extended.
- pop  in  1  consume head entry at this edge.
- clr_sticky  in  1  clear sticky flag register.
- bus  inout  WIDTH  shared data bus.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- ovf_err  out  1  sticky error: a push hit a full queue.

Behaviour:
- Reset (grst_n=0 or lrst=1 at an edge):
  - rd/wr pointers = 0, count = 0, sticky = 0, ovf_err = 0.
  - Therefore empty = 1, full = 0.
  - Reset dominates all other inputs in that cycle.
  - Storage array is not reset.
- Push: an edge with op_sel != 0 writes {flags, res} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: an edge with pop=1 and count>0 advances rd_ptr modulo DEPTH. Pop when empty is ignored; no error is raised.
- Push and pop in the same cycle:
  - Not full, not empty: both occur, count unchanged.
  - Empty: push only, count becomes 1.
  - Full: both occur, count stays DEPTH, ovf_err unchanged.
- Push when full without pop:
  - OVERWRITE=1: entry stored, rd_ptr advances (oldest lost), count stays DEPTH, ovf_err <= 1.
  - OVERWRITE=0: push discarded, storage and pointers unchanged, ovf_err <= 1.
- ovf_err is cleared only by reset or lrst.
- Latency:
  - A push into an empty queue is visible at the head (ws1/ws2) from the cycle after the edge.
  - count, full and empty are registered-state derived and update at the same edge.
- Sticky flags:
  - Every push request ORs {N,O,C,Z} into sticky, including pushes discarded under OVERWRITE=0.
  - clr_sticky with a simultaneous push gives sticky = the new flags only (clear, then OR).
- Bus drive (combinational, priority ws1 > ws2 > ws3):
  - ws1 drives the head result; ws2 drives the head flags; ws3 drives sticky.
  - With no select asserted, bus = all Z.
  - If empty, ws1/ws2 drive all zeros rather than stale storage.
- The block never samples bus as an input.
- count width holds the value DEPTH exactly; pointers are $clog2(DEPTH) bits and wrap naturally.

Decomposition:
- Shared package: FLAG_Z=0, FLAG_C=1, FLAG_O=2, FLAG_N=3 bit indices; OP_NOP = 2'b00; the flag-vector width constant NFLAGS=4.
- One natural sub-module, regr_queue_ctrl: pointer/count/full/empty/ovf_err logic, parametrised by DEPTH and OVERWRITE.
- Storage, sticky register and bus mux stay in regr_queue.

Test Plan:
- Reset then idle: grst_n=0 for 1 edge, no selects -> count=0, empty=1, full=0, ovf_err=0, bus=ZZZZ; ws1=1 -> bus=0000.
- Ordered readback (WIDTH=4, DEPTH=4): push res=3,5,9 (flags Z=0,C=1), then ws1+pop for 3 cycles -> bus shows 3,5,9 in order; ws2 shows 0010; count goes 3->0, empty=1 after last pop.
- Overflow with OVERWRITE=1: push 1,2,3,4,5 with no pop -> full=1, count=4, ovf_err=1, readback 2,3,4,5. Same stimulus with OVERWRITE=0 -> readback 1,2,3,4, ovf_err=1.
- Simultaneous push+pop: when full, push 6 + pop -> count stays 4, head advances one entry, ovf_err unchanged. When empty, push 7 + pop -> count=1, head=7.
- Sticky flags: push with Z=1, then with N=1 -> ws3 bus=1001. clr_sticky with a simultaneous push of C=1 -> ws3 bus=0010.
- Local clear mid-operation: queue holding 3 entries, lrst=1 for one edge with simultaneous push -> count=0, empty=1, sticky=0, ovf_err=0; push is discarded.
